sd_multiblock_reader: RTL and testbench
=======================================

// Module: sd_multiblock_reader
// PURPOSE
//  Multi-block read sequencer between the bus/core and the SD controller (sd_top). Reads i_BLOCK_COUNT
//  consecutive 512-byte blocks from a programmable start address. Packs the controller's nibble
//  stream into DATA_W-bit words and buffers them in a FIFO with a valid/ready output stream.
//  Reports errors, restarts, framing faults and timeouts; supports abort.
// PARAMETERS
//  DATA_W      32   output word width; multiple of 4 that divides 4096. WPB = 4096/DATA_W words per block
//  FIFO_DEPTH  128  FIFO depth in words; power of 2, >= WPB
//  CNT_W       16   width of block count / progress counter
//  TIMEOUT_W   20   idle-nibble watchdog width; fires after 2**TIMEOUT_W-1 cycles
// PORTS
//  CLK                  in   1       system clock
//  a_RST_N              in   1       asynchronous active-low reset
//  i_START              in   1       start pulse; accepted only when o_BUSY=0
//  i_START_ADDR         in   24      first block address (byte address bits [32:9])
//  i_BLOCK_COUNT        in   CNT_W   blocks to read; 0 = no-op
//  i_ABORT              in   1       terminate the current transfer
//  o_BUSY               out  1       transfer in progress
//  o_DONE               out  1       1-cycle pulse at end of transfer (success, error or abort)
//  o_ERROR              out  1       sticky error flag; cleared by an accepted i_START
//  o_ERROR_CODE         out  4       0x0-0x7 = SD fatal code; 8 restart, 9 framing, A timeout, B abort
//  o_BLOCKS_DONE        out  CNT_W   blocks fully received in this transfer
//  i_SD_READY_FOR_READ  in   1       controller idle, ready for a request
//  i_SD_RESTARTING      in   1       controller is reinitialising
//  i_SD_FATAL_ERROR     in   1       controller fatal error
//  i_SD_ERROR_CODE      in   3       controller error code
//  o_SD_READ_REQUEST    out  1       1-cycle read request pulse
//  o_SD_BLOCK_ADDR      out  24      block address for the current request
//  i_SD_DATA            in   4       nibble from controller
//  i_SD_DATA_VALID      in   1       nibble valid
//  i_SD_LAST_NIBBLE     in   1       last nibble of the block (qualified by valid)
//  o_WORD               out  DATA_W  FIFO head word
//  o_WORD_VALID         out  1       FIFO non-empty
//  i_WORD_READY         in   1       consumer pops when valid&ready
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, state IDLE, counters and packing register cleared. This holds from any state.
//  States:
//   - IDLE: accepted i_START latches addr/count, clears o_ERROR/code/o_BLOCKS_DONE and asserts o_BUSY.
//     Next state is ISSUE, or DONE if count=0.
//   - ISSUE: when i_SD_READY_FOR_READ=1 and FIFO free >= WPB (evaluated on registered occupancy), pulse o_SD_READ_REQUEST for one cycle and go to RECV.
//     o_SD_BLOCK_ADDR is stable throughout ISSUE and RECV.
//   - RECV: each valid nibble shifts into the packer. The first nibble received lands in bits [DATA_W-1:DATA_W-4].
//     After DATA_W/4 nibbles the word is pushed. Nibbles per block are counted.
//     On valid&last: if the count is 1024, the block is complete: o_BLOCKS_DONE++ and address+1 (mod 2**24).
//     Then go to DONE if o_BLOCKS_DONE reaches count, else go to ISSUE. A last nibble at any other count is a framing error (9).
//   - DONE: pulse o_DONE, clear o_BUSY, return to IDLE. Data still in the FIFO remains drainable, and a new i_START is legal.
//   - ERR: set o_ERROR and code, flush the FIFO and packer, then go to DONE.
//  Error priority in ISSUE/RECV: i_ABORT (B) > i_SD_FATAL_ERROR ({1'b0,code}) > i_SD_RESTARTING (8) > framing (9) > timeout (A).
//  Timeout: counter runs in RECV, resets on every valid nibble, and fires after 2**TIMEOUT_W-1 idle cycles. ISSUE has no timeout.
//  i_ABORT in IDLE/DONE is ignored. i_ABORT and i_START in the same IDLE cycle: start is taken, abort is ignored.
//  i_START while busy is ignored.
//  Latency: a word is visible on o_WORD_VALID in the cycle after its final nibble is sampled (first-word fall-through).
//  FIFO: push and pop in the same cycle are both honoured. Pop with o_WORD_VALID=0 has no effect.
//   Overflow is impossible by the ISSUE space check, and the bench asserts this.
//  Arithmetic: block address wraps 0xFFFFFF->0x000000. o_BLOCKS_DONE never exceeds i_BLOCK_COUNT.
// TESTING
//  - addr 0x000010, count 1, nibbles 0..F repeating, ready=1:
//    one request with addr 0x000010, 128 words, first 0x01234567, o_DONE pulse, o_BLOCKS_DONE=1.
//  - count 3, i_WORD_READY=0 after block 1 (FIFO full):
//    no 2nd request until 128 words popped, then blocks 2 and 3 complete with o_BLOCKS_DONE=3.
//  - addr 0xFFFFFF, count 2: second request carries o_SD_BLOCK_ADDR=0x000000.
//  - i_SD_FATAL_ERROR with code 3'b011 at nibble 500:
//    o_ERROR=1, code 0x3, FIFO empty, o_DONE pulse, o_BUSY=0; next i_START clears o_ERROR.
//  - last nibble at nibble 1000 -> code 0x9. No nibbles for 2**TIMEOUT_W-1 cycles in RECV -> code 0xA.
//  - count 0 -> o_DONE next cycle, no request. i_ABORT mid-RECV -> code 0xB. Reset mid-RECV -> all outputs 0.

Source files
------------

// File: rtl/sd_multiblock_reader.sv
// sd_multiblock_reader: issues consecutive single-block reads to the SD
// controller, packs the returned nibble stream into DATA_W-bit words and
// buffers them in a first-word-fall-through FIFO with a valid/ready output.
module sd_multiblock_reader #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 128,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT_W  = 20
) (
  input  logic              CLK,
  input  logic              a_RST_N,
  input  logic              i_START,
  input  logic [23:0]       i_START_ADDR,
  input  logic [CNT_W-1:0]  i_BLOCK_COUNT,
  input  logic              i_ABORT,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_ERROR,
  output logic [3:0]        o_ERROR_CODE,
  output logic [CNT_W-1:0]  o_BLOCKS_DONE,
  input  logic              i_SD_READY_FOR_READ,
  input  logic              i_SD_RESTARTING,
  input  logic              i_SD_FATAL_ERROR,
  input  logic [2:0]        i_SD_ERROR_CODE,
  output logic              o_SD_READ_REQUEST,
  output logic [23:0]       o_SD_BLOCK_ADDR,
  input  logic [3:0]        i_SD_DATA,
  input  logic              i_SD_DATA_VALID,
  input  logic              i_SD_LAST_NIBBLE,
  output logic [DATA_W-1:0] o_WORD,
  output logic              o_WORD_VALID,
  input  logic              i_WORD_READY
);

  localparam int WPB = 4096 / DATA_W;
  localparam int NPW = DATA_W / 4;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PCW = (NPW > 1) ? $clog2(NPW) : 1;

  localparam logic [10:0]          LAST_NIB   = 11'd1023;
  localparam logic [TIMEOUT_W-1:0] TIMER_FIRE = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [AW:0]          DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]          WPB_C      = (AW+1)'(WPB);
  localparam logic [PCW-1:0]       PACK_LAST  = PCW'(NPW - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RECV, S_DONE, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [23:0]          addr_q, addr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     blocks_q, blocks_d;
  logic                 error_q, error_d;
  logic [3:0]           code_q, code_d;
  logic [3:0]           pend_q, pend_d;
  logic [10:0]          nib_q, nib_d;
  logic [DATA_W-1:0]    pack_q, pack_d;
  logic [PCW-1:0]       pcnt_q, pcnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;

  logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          fifo_cnt_q;

  logic                 push, pop, flush, req;
  logic                 hard_err;
  logic [3:0]           hard_code;
  logic                 free_ok;
  logic [DATA_W-1:0]    pack_shift;

  // A new block may only be requested when the whole block fits in the FIFO.
  assign free_ok    = (DEPTH_C - fifo_cnt_q) >= WPB_C;
  assign pack_shift = (pack_q << 4) | DATA_W'(i_SD_DATA);
  assign pop        = o_WORD_VALID & i_WORD_READY;

  // Prioritised external error sources shared by ISSUE and RECV.
  always_comb begin
    hard_err  = 1'b1;
    hard_code = 4'hB;
    if (i_ABORT)               hard_code = 4'hB;
    else if (i_SD_FATAL_ERROR) hard_code = {1'b0, i_SD_ERROR_CODE};
    else if (i_SD_RESTARTING)  hard_code = 4'h8;
    else                       hard_err  = 1'b0;
  end

  // Next-state logic for the transfer sequencer, packer and watchdog.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    blocks_d = blocks_q;
    error_d  = error_q;
    code_d   = code_q;
    pend_d   = pend_q;
    nib_d    = nib_q;
    pack_d   = pack_q;
    pcnt_d   = pcnt_q;
    timer_d  = timer_q;
    push     = 1'b0;
    flush    = 1'b0;
    req      = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_START) begin
          addr_d   = i_START_ADDR;
          count_d  = i_BLOCK_COUNT;
          blocks_d = '0;
          error_d  = 1'b0;
          code_d   = 4'h0;
          state_d  = (i_BLOCK_COUNT == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hard_err) begin
          pend_d  = hard_code;
          state_d = S_ERR;
        end else if (i_SD_READY_FOR_READ && free_ok) begin
          req     = 1'b1;
          nib_d   = '0;
          timer_d = '0;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (hard_err) begin
          pend_d  = hard_code;
          state_d = S_ERR;
        end else if (i_SD_DATA_VALID && i_SD_LAST_NIBBLE && (nib_q != LAST_NIB)) begin
          pend_d  = 4'h9;
          state_d = S_ERR;
        end else if (i_SD_DATA_VALID) begin
          timer_d = '0;
          pack_d  = pack_shift;
          nib_d   = nib_q + 11'd1;
          if (pcnt_q == PACK_LAST) begin
            push   = 1'b1;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + PCW'(1);
          end
          if (i_SD_LAST_NIBBLE) begin
            nib_d    = '0;
            blocks_d = blocks_q + CNT_W'(1);
            addr_d   = addr_q + 24'd1;
            state_d  = ((blocks_q + CNT_W'(1)) == count_q) ? S_DONE : S_ISSUE;
          end
        end else if (timer_q == TIMER_FIRE) begin
          pend_d  = 4'hA;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      S_ERR: begin
        error_d = 1'b1;
        code_d  = pend_q;
        flush   = 1'b1;
        pack_d  = '0;
        pcnt_d  = '0;
        nib_d   = '0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer, packer and watchdog registers.
  always_ff @(posedge CLK or negedge a_RST_N) begin
    if (!a_RST_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      blocks_q <= '0;
      error_q  <= 1'b0;
      code_q   <= 4'h0;
      pend_q   <= 4'h0;
      nib_q    <= '0;
      pack_q   <= '0;
      pcnt_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      blocks_q <= blocks_d;
      error_q  <= error_d;
      code_q   <= code_d;
      pend_q   <= pend_d;
      nib_q    <= nib_d;
      pack_q   <= pack_d;
      pcnt_q   <= pcnt_d;
      timer_q  <= timer_d;
    end
  end

  // FIFO pointers and occupancy; a flush on error discards everything buffered.
  always_ff @(posedge CLK or negedge a_RST_N) begin
    if (!a_RST_N) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
    end else if (flush) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (AW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (AW+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= pack_shift;
  end

  assign o_BUSY            = (state_q == S_ISSUE) || (state_q == S_RECV) || (state_q == S_ERR);
  assign o_DONE            = (state_q == S_DONE);
  assign o_ERROR           = error_q;
  assign o_ERROR_CODE      = code_q;
  assign o_BLOCKS_DONE     = blocks_q;
  assign o_SD_READ_REQUEST = req;
  assign o_SD_BLOCK_ADDR   = addr_q;
  assign o_WORD_VALID      = (fifo_cnt_q != '0);
  assign o_WORD            = o_WORD_VALID ? mem_q[rd_q] : '0;

endmodule

// File: tb/tb_sd_multiblock_reader.sv
// Directed testbench for sd_multiblock_reader: one task per scenario, each
// with its own hand-computed expectations.
module tb_sd_multiblock_reader;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 128;
  localparam int CNT_W      = 16;
  localparam int TIMEOUT_W  = 8;

  logic              CLK = 1'b0;
  logic              a_RST_N;
  logic              i_START;
  logic [23:0]       i_START_ADDR;
  logic [CNT_W-1:0]  i_BLOCK_COUNT;
  logic              i_ABORT;
  logic              o_BUSY;
  logic              o_DONE;
  logic              o_ERROR;
  logic [3:0]        o_ERROR_CODE;
  logic [CNT_W-1:0]  o_BLOCKS_DONE;
  logic              i_SD_READY_FOR_READ;
  logic              i_SD_RESTARTING;
  logic              i_SD_FATAL_ERROR;
  logic [2:0]        i_SD_ERROR_CODE;
  logic              o_SD_READ_REQUEST;
  logic [23:0]       o_SD_BLOCK_ADDR;
  logic [3:0]        i_SD_DATA;
  logic              i_SD_DATA_VALID;
  logic              i_SD_LAST_NIBBLE;
  logic [DATA_W-1:0] o_WORD;
  logic              o_WORD_VALID;
  logic              i_WORD_READY;

  int compared   = 0;
  int mismatched = 0;
  int reqCount   = 0;
  int doneCount  = 0;
  int popCount   = 0;
  bit overflowSeen = 1'b0;
  logic [23:0]       reqAddr[$];
  logic [DATA_W-1:0] popped[$];

  sd_multiblock_reader #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .CLK(CLK), .a_RST_N(a_RST_N),
    .i_START(i_START), .i_START_ADDR(i_START_ADDR), .i_BLOCK_COUNT(i_BLOCK_COUNT),
    .i_ABORT(i_ABORT), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERROR(o_ERROR),
    .o_ERROR_CODE(o_ERROR_CODE), .o_BLOCKS_DONE(o_BLOCKS_DONE),
    .i_SD_READY_FOR_READ(i_SD_READY_FOR_READ), .i_SD_RESTARTING(i_SD_RESTARTING),
    .i_SD_FATAL_ERROR(i_SD_FATAL_ERROR), .i_SD_ERROR_CODE(i_SD_ERROR_CODE),
    .o_SD_READ_REQUEST(o_SD_READ_REQUEST), .o_SD_BLOCK_ADDR(o_SD_BLOCK_ADDR),
    .i_SD_DATA(i_SD_DATA), .i_SD_DATA_VALID(i_SD_DATA_VALID),
    .i_SD_LAST_NIBBLE(i_SD_LAST_NIBBLE), .o_WORD(o_WORD), .o_WORD_VALID(o_WORD_VALID),
    .i_WORD_READY(i_WORD_READY)
  );

  always #5 CLK = ~CLK;

  // Record requests, done pulses and popped words mid-cycle; inputs only change just after posedge.
  always @(negedge CLK) begin
    if (a_RST_N) begin
      if (o_SD_READ_REQUEST) begin
        reqCount++;
        reqAddr.push_back(o_SD_BLOCK_ADDR);
      end
      if (o_DONE) doneCount++;
      if (o_WORD_VALID && i_WORD_READY) begin
        popCount++;
        popped.push_back(o_WORD);
      end
      assert (int'(dut.fifo_cnt_q) <= FIFO_DEPTH) else begin
        overflowSeen = 1'b1;
        $display("[TB] FAIL fifo_overflow: occupancy %0d, limit %0d", dut.fifo_cnt_q, FIFO_DEPTH);
      end
    end
  end

  // Hard stop in case something unbounded slips through.
  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_xfer(input logic [23:0] addr, input logic [CNT_W-1:0] cnt);
    i_START       = 1'b1;
    i_START_ADDR  = addr;
    i_BLOCK_COUNT = cnt;
    tick(1);
    i_START       = 1'b0;
  endtask

  // Waits for request number base+1, then drives n nibbles (value = index mod 16).
  task automatic feed_block(input int base, input int first, input int n, input bit withLast);
    int c;
    c = 0;
    while (reqCount <= base && c < 3000) begin
      tick(1);
      c++;
    end
    if (reqCount <= base) begin
      compared++; mismatched++;
      $display("[TB] FAIL request_wait: got %0d requests, required more than %0d", reqCount, base);
      return;
    end
    for (int k = 0; k < n; k++) begin
      i_SD_DATA        = 4'((first + k) % 16);
      i_SD_DATA_VALID  = 1'b1;
      i_SD_LAST_NIBBLE = withLast && (k == n - 1);
      tick(1);
    end
    i_SD_DATA_VALID  = 1'b0;
    i_SD_LAST_NIBBLE = 1'b0;
    i_SD_DATA        = 4'h0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int c;
    c = 0;
    while (doneCount <= base && c < budget) begin
      tick(1);
      c++;
    end
    compared++;
    if (doneCount <= base) begin
      mismatched++;
      $display("[TB] FAIL done_wait: got %0d done pulses, required %0d", doneCount - base, 1);
    end
  endtask

  task automatic test_reset();
    a_RST_N = 1'b0; i_START = 0; i_START_ADDR = 0; i_BLOCK_COUNT = 0; i_ABORT = 0;
    i_SD_READY_FOR_READ = 1; i_SD_RESTARTING = 0; i_SD_FATAL_ERROR = 0; i_SD_ERROR_CODE = 0;
    i_SD_DATA = 0; i_SD_DATA_VALID = 0; i_SD_LAST_NIBBLE = 0; i_WORD_READY = 1;
    #12;
    compared++;
    if ({o_BUSY, o_DONE, o_ERROR, o_ERROR_CODE, o_BLOCKS_DONE, o_SD_READ_REQUEST,
         o_SD_BLOCK_ADDR, o_WORD, o_WORD_VALID} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b err=%b code=%h blk=%0d valid=%b, required all 0",
               o_BUSY, o_DONE, o_ERROR, o_ERROR_CODE, o_BLOCKS_DONE, o_WORD_VALID);
    end
    @(posedge CLK); #1;
    a_RST_N = 1'b1;
    tick(2);
    compared++;
    if (o_BUSY !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_idle_busy: got %b, required 0", o_BUSY); end
  endtask

  task automatic test_single_block();
    int rb, pb, db;
    rb = reqCount; pb = popCount; db = doneCount;
    start_xfer(24'h000010, 16'd1);
    feed_block(rb, 0, 1024, 1'b1);
    wait_done(db, 20);
    tick(3);
    compared++; if (reqCount - rb !== 1) begin mismatched++; $display("[TB] FAIL single_req_count: got %0d, required 1", reqCount - rb); end
    compared++; if (reqAddr[rb] !== 24'h000010) begin mismatched++; $display("[TB] FAIL single_req_addr: got %h, required 000010", reqAddr[rb]); end
    compared++; if (popCount - pb !== 128) begin mismatched++; $display("[TB] FAIL single_word_count: got %0d, required 128", popCount - pb); end
    if (popCount - pb >= 128) begin
      compared++; if (popped[pb] !== 32'h01234567) begin mismatched++; $display("[TB] FAIL single_word0: got %h, required 01234567", popped[pb]); end
      compared++; if (popped[pb+1] !== 32'h89ABCDEF) begin mismatched++; $display("[TB] FAIL single_word1: got %h, required 89abcdef", popped[pb+1]); end
      compared++; if (popped[pb+127] !== 32'h89ABCDEF) begin mismatched++; $display("[TB] FAIL single_word127: got %h, required 89abcdef", popped[pb+127]); end
    end
    compared++; if (o_BLOCKS_DONE !== 16'd1) begin mismatched++; $display("[TB] FAIL single_blocks_done: got %0d, required 1", o_BLOCKS_DONE); end
    compared++; if (doneCount - db !== 1) begin mismatched++; $display("[TB] FAIL single_done_pulses: got %0d, required 1", doneCount - db); end
    compared++; if ({o_BUSY, o_ERROR} !== 2'b00) begin mismatched++; $display("[TB] FAIL single_busy_err: got %b, required 00", {o_BUSY, o_ERROR}); end
  endtask

  task automatic test_back_to_back();
    int rb, pb, db;
    rb = reqCount; pb = popCount; db = doneCount;
    i_WORD_READY = 1'b0;
    start_xfer(24'h000100, 16'd3);
    feed_block(rb, 0, 1024, 1'b1);
    tick(30);
    compared++; if (reqCount - rb !== 1) begin mismatched++; $display("[TB] FAIL bp_full_no_req: got %0d requests, required 1", reqCount - rb); end
    compared++; if ({o_WORD_VALID, o_BUSY} !== 2'b11) begin mismatched++; $display("[TB] FAIL bp_full_state: got %b, required 11", {o_WORD_VALID, o_BUSY}); end
    compared++; if (o_BLOCKS_DONE !== 16'd1) begin mismatched++; $display("[TB] FAIL bp_blocks_1: got %0d, required 1", o_BLOCKS_DONE); end
    i_WORD_READY = 1'b1;
    tick(127);
    i_WORD_READY = 1'b0;
    tick(20);
    compared++; if (reqCount - rb !== 1) begin mismatched++; $display("[TB] FAIL bp_one_left_no_req: got %0d requests, required 1", reqCount - rb); end
    compared++; if (popCount - pb !== 127) begin mismatched++; $display("[TB] FAIL bp_pop127: got %0d, required 127", popCount - pb); end
    i_WORD_READY = 1'b1;
    feed_block(rb + 1, 0, 1024, 1'b1);
    feed_block(rb + 2, 0, 1024, 1'b1);
    wait_done(db, 50);
    tick(3);
    compared++; if (o_BLOCKS_DONE !== 16'd3) begin mismatched++; $display("[TB] FAIL bp_blocks_3: got %0d, required 3", o_BLOCKS_DONE); end
    compared++; if (reqCount - rb !== 3) begin mismatched++; $display("[TB] FAIL bp_req_3: got %0d, required 3", reqCount - rb); end
    compared++; if (popCount - pb !== 384) begin mismatched++; $display("[TB] FAIL bp_words_384: got %0d, required 384", popCount - pb); end
    if (reqCount - rb >= 3) begin
      compared++; if (reqAddr[rb+2] !== 24'h000102) begin mismatched++; $display("[TB] FAIL bp_req3_addr: got %h, required 000102", reqAddr[rb+2]); end
    end
  endtask

  task automatic test_addr_wrap();
    int rb, db;
    rb = reqCount; db = doneCount;
    start_xfer(24'hFFFFFF, 16'd2);
    feed_block(rb, 0, 1024, 1'b1);
    feed_block(rb + 1, 0, 1024, 1'b1);
    wait_done(db, 20);
    compared++; if (reqCount - rb !== 2) begin mismatched++; $display("[TB] FAIL wrap_req_count: got %0d, required 2", reqCount - rb); end
    if (reqCount - rb >= 2) begin
      compared++; if (reqAddr[rb] !== 24'hFFFFFF) begin mismatched++; $display("[TB] FAIL wrap_addr0: got %h, required ffffff", reqAddr[rb]); end
      compared++; if (reqAddr[rb+1] !== 24'h000000) begin mismatched++; $display("[TB] FAIL wrap_addr1: got %h, required 000000", reqAddr[rb+1]); end
    end
    compared++; if (o_SD_BLOCK_ADDR !== 24'h000001) begin mismatched++; $display("[TB] FAIL wrap_final_addr: got %h, required 000001", o_SD_BLOCK_ADDR); end
  endtask

  task automatic test_fatal_error();
    int rb, db;
    rb = reqCount; db = doneCount;
    i_WORD_READY = 1'b0;
    start_xfer(24'h000020, 16'd1);
    feed_block(rb, 0, 7, 1'b0);
    compared++; if (o_WORD_VALID !== 1'b0) begin mismatched++; $display("[TB] FAIL fwft_before: got %b, required 0", o_WORD_VALID); end
    feed_block(rb, 7, 1, 1'b0);
    compared++; if (o_WORD_VALID !== 1'b1) begin mismatched++; $display("[TB] FAIL fwft_valid: got %b, required 1", o_WORD_VALID); end
    compared++; if (o_WORD !== 32'h01234567) begin mismatched++; $display("[TB] FAIL fwft_word: got %h, required 01234567", o_WORD); end
    feed_block(rb, 8, 491, 1'b0);
    i_SD_FATAL_ERROR = 1'b1; i_SD_ERROR_CODE = 3'b011;
    i_SD_DATA = 4'h3; i_SD_DATA_VALID = 1'b1;
    tick(1);
    i_SD_FATAL_ERROR = 1'b0; i_SD_ERROR_CODE = 3'b000; i_SD_DATA_VALID = 1'b0;
    wait_done(db, 20);
    compared++; if ({o_ERROR, o_ERROR_CODE} !== 5'h13) begin mismatched++; $display("[TB] FAIL fatal_code: got err=%b code=%h, required err=1 code=3", o_ERROR, o_ERROR_CODE); end
    compared++; if ({o_WORD_VALID, o_BUSY} !== 2'b00) begin mismatched++; $display("[TB] FAIL fatal_flush: got valid/busy %b, required 00", {o_WORD_VALID, o_BUSY}); end
    compared++; if (o_BLOCKS_DONE !== 16'd0) begin mismatched++; $display("[TB] FAIL fatal_blocks: got %0d, required 0", o_BLOCKS_DONE); end
    i_WORD_READY = 1'b1;
  endtask

  task automatic test_count_zero();
    int rb;
    rb = reqCount;
    start_xfer(24'h000030, 16'd0);
    compared++; if ({o_DONE, o_BUSY, o_ERROR, o_ERROR_CODE} !== 7'b1000000) begin mismatched++; $display("[TB] FAIL zero_done: got done=%b busy=%b err=%b code=%h, required 1 0 0 0", o_DONE, o_BUSY, o_ERROR, o_ERROR_CODE); end
    tick(1);
    compared++; if (o_DONE !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_pulse_len: got %b, required 0", o_DONE); end
    tick(5);
    compared++; if (reqCount - rb !== 0) begin mismatched++; $display("[TB] FAIL zero_no_req: got %0d, required 0", reqCount - rb); end
  endtask

  task automatic test_framing();
    int rb, db;
    rb = reqCount; db = doneCount;
    start_xfer(24'h000040, 16'd1);
    feed_block(rb, 0, 1000, 1'b1);
    wait_done(db, 20);
    compared++; if ({o_ERROR, o_ERROR_CODE} !== 5'h19) begin mismatched++; $display("[TB] FAIL framing_code: got err=%b code=%h, required err=1 code=9", o_ERROR, o_ERROR_CODE); end
    compared++; if (o_BLOCKS_DONE !== 16'd0) begin mismatched++; $display("[TB] FAIL framing_blocks: got %0d, required 0", o_BLOCKS_DONE); end
  endtask

  task automatic test_timeout();
    int rb, db;
    rb = reqCount; db = doneCount;
    start_xfer(24'h000050, 16'd1);
    feed_block(rb, 0, 0, 1'b0);
    start_xfer(24'h000099, 16'd0);
    tick(200);
    compared++; if ({o_BUSY, o_ERROR} !== 2'b10) begin mismatched++; $display("[TB] FAIL timeout_early: got busy/err %b, required 10", {o_BUSY, o_ERROR}); end
    compared++; if (o_SD_BLOCK_ADDR !== 24'h000050) begin mismatched++; $display("[TB] FAIL busy_start_ignored: got %h, required 000050", o_SD_BLOCK_ADDR); end
    compared++; if (doneCount - db !== 0) begin mismatched++; $display("[TB] FAIL timeout_no_done: got %0d, required 0", doneCount - db); end
    wait_done(db, 200);
    compared++; if ({o_ERROR, o_ERROR_CODE} !== 5'h1A) begin mismatched++; $display("[TB] FAIL timeout_code: got err=%b code=%h, required err=1 code=a", o_ERROR, o_ERROR_CODE); end
  endtask

  task automatic test_abort();
    int rb, db;
    rb = reqCount; db = doneCount;
    i_ABORT = 1'b1;
    tick(2);
    i_ABORT = 1'b0;
    tick(1);
    compared++; if ({o_BUSY, o_ERROR, o_ERROR_CODE} !== 6'b01_1010) begin mismatched++; $display("[TB] FAIL idle_abort: got busy=%b err=%b code=%h, required 0 1 a", o_BUSY, o_ERROR, o_ERROR_CODE); end
    compared++; if (doneCount - db !== 0) begin mismatched++; $display("[TB] FAIL idle_abort_done: got %0d, required 0", doneCount - db); end
    i_ABORT = 1'b1;
    start_xfer(24'h000060, 16'd1);
    i_ABORT = 1'b0;
    compared++; if ({o_BUSY, o_ERROR} !== 2'b10) begin mismatched++; $display("[TB] FAIL start_with_abort: got busy/err %b, required 10", {o_BUSY, o_ERROR}); end
    feed_block(rb, 0, 300, 1'b0);
    i_ABORT = 1'b1;
    tick(1);
    i_ABORT = 1'b0;
    wait_done(db, 20);
    compared++; if ({o_ERROR, o_ERROR_CODE, o_BUSY} !== 6'b1_1011_0) begin mismatched++; $display("[TB] FAIL abort_code: got err=%b code=%h busy=%b, required 1 b 0", o_ERROR, o_ERROR_CODE, o_BUSY); end
  endtask

  task automatic test_reset_mid_recv();
    int rb;
    rb = reqCount;
    i_WORD_READY = 1'b0;
    start_xfer(24'h000070, 16'd1);
    feed_block(rb, 0, 400, 1'b0);
    compared++; if ({o_BUSY, o_WORD_VALID} !== 2'b11) begin mismatched++; $display("[TB] FAIL pre_reset_state: got %b, required 11", {o_BUSY, o_WORD_VALID}); end
    #2;
    a_RST_N = 1'b0;
    #1;
    compared++;
    if ({o_BUSY, o_DONE, o_ERROR, o_ERROR_CODE, o_BLOCKS_DONE, o_SD_READ_REQUEST,
         o_SD_BLOCK_ADDR, o_WORD, o_WORD_VALID} !== '0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got busy=%b addr=%h word=%h valid=%b, required all 0",
               o_BUSY, o_SD_BLOCK_ADDR, o_WORD, o_WORD_VALID);
    end
    @(posedge CLK); #1;
    a_RST_N = 1'b1;
    i_WORD_READY = 1'b1;
    tick(3);
    compared++; if ({o_BUSY, o_WORD_VALID} !== 2'b00) begin mismatched++; $display("[TB] FAIL post_reset_idle: got %b, required 00", {o_BUSY, o_WORD_VALID}); end
  endtask

  task automatic test_no_overflow();
    compared++;
    if (overflowSeen !== 1'b0) begin mismatched++; $display("[TB] FAIL fifo_never_overflowed: got %b, required 0", overflowSeen); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_addr_wrap();
    test_fatal_error();
    test_count_zero();
    test_framing();
    test_timeout();
    test_abort();
    test_reset_mid_recv();
    test_no_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
